// File: rtl/clause_literal_streamer_pkg.sv
// Shared solver definitions for the clause literal streamer: FSM state,
// literal-kind encoding and the index output width helper.
package clause_literal_streamer_pkg;

  // Streamer FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInt  = 2'd1,
    StBool = 2'd2,
    StDone = 2'd3
  } state_e;

  // Literal kind as driven on out_is_boolean.
  localparam logic KIND_INTEGER = 1'b0;
  localparam logic KIND_BOOLEAN = 1'b1;

  // Width of the shared index output: the wider of the two kinds, at least 1.
  function automatic int unsigned index_width(input int unsigned int_index_bits,
                                              input int unsigned bool_index_bits);
    int unsigned w;
    w = (int_index_bits > bool_index_bits) ? int_index_bits : bool_index_bits;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/lowest_set_bit_finder.sv
// Priority encoder: reports whether any bit of the mask is set and the
// position of the lowest set bit.
module lowest_set_bit_finder #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned INDEX_WIDTH = 1
) (
  input  logic [WIDTH-1:0]       mask,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = |mask;
    index = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (mask[i]) index = INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/clause_literal_streamer.sv
// Clause literal streamer: loads one packed clause and serialises its nonzero
// integer then boolean coefficients as (kind, index, coefficient) literals over
// a valid/ready handshake. Zero-coefficient variables are skipped.
//
// Optional feature macro: CLAUSE_LITERAL_STREAMER_COUNT_EN adds out_literal_count,
// the number of literals in the clause, captured on the load edge.
module clause_literal_streamer
  import clause_literal_streamer_pkg::*;
#(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2
) (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_start,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)*
                MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] in_integer_coefficients,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)*
                MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT-1:0] in_boolean_coefficients,
  input  logic in_ready,
  output logic out_valid,
  output logic out_is_boolean,
  output logic [index_width(MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
                            MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] out_index,
  output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] out_coefficient,
  output logic out_busy,
`ifdef CLAUSE_LITERAL_STREAMER_COUNT_EN
  output logic [$clog2((2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX) +
                       (2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX) + 1)-1:0]
               out_literal_count,
`endif
  output logic out_done
);

  localparam int unsigned IW   = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
  localparam int unsigned BW   = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int unsigned CI   = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
  localparam int unsigned CB   = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT;
  localparam int unsigned NI   = 2 ** IW;
  localparam int unsigned NB   = 2 ** BW;
  localparam int unsigned IDXW = index_width(IW, BW);
  // Finder index widths; a single-slot kind still gets a 1-bit index.
  localparam int unsigned IFW  = (IW > 0) ? IW : 1;
  localparam int unsigned BFW  = (BW > 0) ? BW : 1;

  state_e state_q, state_d;

  logic [NI-1:0]    int_present, int_mask_q, int_mask_rest;
  logic [NB-1:0]    bool_present, bool_mask_q, bool_mask_rest;
  logic [NI*CI-1:0] int_coef_q;
  logic [NB*CB-1:0] bool_coef_q;

  logic           int_found, bool_found;
  logic [IFW-1:0] int_idx;
  logic [BFW-1:0] bool_idx;
  logic [CI-1:0]  int_coef_sel;
  logic [CB-1:0]  bool_coef_sel;

  logic load, accept;

  assign load   = (state_q == StIdle) && in_start;
  // out_valid is decoded from registered state only, so accept never loops.
  assign accept = out_valid && in_ready;

  // Presence masks built straight from the inputs for capture on the load edge.
  always_comb begin
    int_present  = '0;
    bool_present = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      int_present[i] = |in_integer_coefficients[i*CI +: CI];
    end
    for (int unsigned j = 0; j < NB; j++) begin
      bool_present[j] = |in_boolean_coefficients[j*CB +: CB];
    end
  end

  // Remaining masks once the current (lowest) literal is accepted.
  always_comb begin
    int_mask_rest  = int_mask_q & (int_mask_q - NI'(1));
    bool_mask_rest = bool_mask_q & (bool_mask_q - NB'(1));
  end

  lowest_set_bit_finder #(
    .WIDTH       (NI),
    .INDEX_WIDTH (IFW)
  ) u_int_finder (
    .mask  (int_mask_q),
    .found (int_found),
    .index (int_idx)
  );

  lowest_set_bit_finder #(
    .WIDTH       (NB),
    .INDEX_WIDTH (BFW)
  ) u_bool_finder (
    .mask  (bool_mask_q),
    .found (bool_found),
    .index (bool_idx)
  );

  // Coefficient multiplexers keyed by the finder indices.
  always_comb begin
    int_coef_sel  = '0;
    bool_coef_sel = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      if (int_idx == IFW'(i)) int_coef_sel = int_coef_q[i*CI +: CI];
    end
    for (int unsigned j = 0; j < NB; j++) begin
      if (bool_idx == BFW'(j)) bool_coef_sel = bool_coef_q[j*CB +: CB];
    end
  end

  // Clause storage: captured on load, mask bits retired on acceptance.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      int_mask_q  <= '0;
      bool_mask_q <= '0;
      int_coef_q  <= '0;
      bool_coef_q <= '0;
    end else if (load) begin
      int_mask_q  <= int_present;
      bool_mask_q <= bool_present;
      int_coef_q  <= in_integer_coefficients;
      bool_coef_q <= in_boolean_coefficients;
    end else if (accept) begin
      if (state_q == StInt) begin
        int_mask_q <= int_mask_rest;
      end else begin
        bool_mask_q <= bool_mask_rest;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: empty kinds are skipped in the same transition, no bubble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          if (|int_present) begin
            state_d = StInt;
          end else if (|bool_present) begin
            state_d = StBool;
          end else begin
            state_d = StDone;
          end
        end
      end
      StInt: begin
        if (accept && (int_mask_rest == '0)) begin
          state_d = (bool_mask_q != '0) ? StBool : StDone;
        end
      end
      StBool: begin
        if (accept && (bool_mask_rest == '0)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs: literal fields are zero whenever no literal is offered.
  always_comb begin
    out_valid       = 1'b0;
    out_is_boolean  = KIND_INTEGER;
    out_index       = '0;
    out_coefficient = '0;
    unique case (state_q)
      StInt: begin
        if (int_found) begin
          out_valid       = 1'b1;
          out_index       = IDXW'(int_idx);
          out_coefficient = int_coef_sel;
        end
      end
      StBool: begin
        if (bool_found) begin
          out_valid       = 1'b1;
          out_is_boolean  = KIND_BOOLEAN;
          out_index       = IDXW'(bool_idx);
          out_coefficient = CI'(bool_coef_sel);
        end
      end
      default: ;
    endcase
    out_busy = (state_q != StIdle);
    out_done = (state_q == StDone);
  end

`ifdef CLAUSE_LITERAL_STREAMER_COUNT_EN
  localparam int unsigned CNTW = $clog2(NI + NB + 1);

  logic [CNTW-1:0] load_count, count_q;

  // Literal count of the clause being loaded.
  always_comb begin
    load_count = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      load_count = load_count + CNTW'(int_present[i]);
    end
    for (int unsigned j = 0; j < NB; j++) begin
      load_count = load_count + CNTW'(bool_present[j]);
    end
  end

  // Count register, held until the next load.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_count;
    end
  end

  assign out_literal_count = count_q;
`endif

endmodule

// File: tb/tb_clause_literal_streamer.sv
// Self-checking bench for clause_literal_streamer at default parameters.
// Expected literals are derived from the loaded vectors into a queue and
// popped as the DUT hands literals over.
module tb_clause_literal_streamer;

  localparam int CI = 4;
  localparam int NI = 2;
  localparam int NB = 2;

  typedef struct {
    logic       kind;
    logic [0:0] idx;
    logic [3:0] coef;
  } lit_t;

  logic       in_clk = 1'b0;
  logic       in_reset;
  logic       in_start;
  logic [7:0] in_integer_coefficients;
  logic [3:0] in_boolean_coefficients;
  logic       in_ready;
  logic       out_valid;
  logic       out_is_boolean;
  logic [0:0] out_index;
  logic [3:0] out_coefficient;
  logic       out_busy;
  logic       out_done;
`ifdef CLAUSE_LITERAL_STREAMER_COUNT_EN
  logic [2:0] out_literal_count;
`endif

  lit_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 in_clk = ~in_clk;

  clause_literal_streamer dut (
    .in_clk                  (in_clk),
    .in_reset                (in_reset),
    .in_start                (in_start),
    .in_integer_coefficients (in_integer_coefficients),
    .in_boolean_coefficients (in_boolean_coefficients),
    .in_ready                (in_ready),
    .out_valid               (out_valid),
    .out_is_boolean          (out_is_boolean),
    .out_index               (out_index),
    .out_coefficient         (out_coefficient),
    .out_busy                (out_busy),
`ifdef CLAUSE_LITERAL_STREAMER_COUNT_EN
    .out_literal_count       (out_literal_count),
`endif
    .out_done                (out_done)
  );

  // Reference model: nonzero integer slots ascending, then nonzero boolean slots.
  task automatic build_expected(input logic [7:0] iv, input logic [3:0] bv, output int n);
    logic [3:0] c;
    logic [1:0] b;
    lit_t       l;
    exp_q.delete();
    n = 0;
    for (int i = 0; i < NI; i++) begin
      c = iv[i*CI +: CI];
      if (c != 4'd0) begin
        l.kind = 1'b0; l.idx = 1'(i); l.coef = c;
        exp_q.push_back(l);
        n++;
      end
    end
    for (int j = 0; j < NB; j++) begin
      b = bv[j*2 +: 2];
      if (b != 2'd0) begin
        l.kind = 1'b1; l.idx = 1'(j); l.coef = {2'b00, b};
        exp_q.push_back(l);
        n++;
      end
    end
  endtask

  task automatic do_start(input logic [7:0] iv, input logic [3:0] bv);
    in_integer_coefficients = iv;
    in_boolean_coefficients = bv;
    in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
  endtask

  task automatic check_count(input int n, input string name);
`ifdef CLAUSE_LITERAL_STREAMER_COUNT_EN
    checks++;
    if (out_literal_count !== 3'(n)) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, out_literal_count, n);
    end
`else
    if (n < 0) $display("%s: negative count", name);
`endif
  endtask

  // Ready modes: 0 always high, 1 low for three cycles then high, 2 toggling.
  task automatic run_stream(input int mode, input int expected_done, input string name);
    bit   done;
    lit_t e;
    done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      in_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc >= 3) : ((cyc % 2) == 0);
      #1;
      checks++;
      if (out_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected 1", name, cyc, out_busy);
      end
      if (out_done === 1'b1) begin
        done = 1'b1;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s done: pending %0d valid %b expected 0 pending, valid 0",
                   name, exp_q.size(), out_valid);
        end
        checks++;
        if (cyc != expected_done) begin
          errors++;
          $display("FAIL %s done cycle: got %0d expected %0d", name, cyc, expected_done);
        end
      end else if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra literal: got (%b,%0d,%h) expected none",
                   name, out_is_boolean, out_index, out_coefficient);
        end else begin
          e = exp_q[0];
          if ({out_is_boolean, out_index, out_coefficient} !== {e.kind, e.idx, e.coef}) begin
            errors++;
            $display("FAIL %s literal cycle %0d: got (%b,%0d,%h) expected (%b,%0d,%h)",
                     name, cyc, out_is_boolean, out_index, out_coefficient,
                     e.kind, e.idx, e.coef);
          end
          if (in_ready) void'(exp_q.pop_front());
        end
      end else if (out_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s valid cycle %0d: got %b expected 0 or 1", name, cyc, out_valid);
      end
      @(posedge in_clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done at cycle %0d", name, expected_done);
    end
    checks++;
    if (out_done !== 1'b0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done %b busy %b expected 0 0", name, out_done, out_busy);
    end
    in_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({out_valid, out_is_boolean, out_index, out_coefficient, out_busy, out_done} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got v%b k%b i%0d c%h busy%b done%b expected all 0", name,
               out_valid, out_is_boolean, out_index, out_coefficient, out_busy, out_done);
    end
  endtask

  task automatic test_reset();
    in_reset = 1'b1;
    in_start = 1'b0;
    in_ready = 1'b0;
    in_integer_coefficients = 8'hFF;
    in_boolean_coefficients = 4'hF;
    repeat (2) @(posedge in_clk);
    #1;
    check_idle_outputs("reset");
    check_count(0, "reset");
    in_reset = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    build_expected(8'h05, 4'b1111, n);
    do_start(8'h05, 4'b1111);
    run_stream(0, n, "basic");
    check_count(n, "basic");
  endtask

  task automatic test_empty();
    int n;
    build_expected(8'h00, 4'b0000, n);
    do_start(8'h00, 4'b0000);
    run_stream(0, 0, "empty");
    check_count(0, "empty");
  endtask

  task automatic test_stall();
    int n;
    build_expected(8'hA0, 4'b0100, n);
    do_start(8'hA0, 4'b0100);
    run_stream(1, n + 3, "stall");
    check_count(n, "stall");
  endtask

  task automatic test_reset_mid();
    int   n;
    lit_t e;
    build_expected(8'h05, 4'b1111, n);
    in_ready = 1'b1;
    do_start(8'h05, 4'b1111);
    e = exp_q[0];
    checks++;
    if (out_valid !== 1'b1 ||
        {out_is_boolean, out_index, out_coefficient} !== {e.kind, e.idx, e.coef}) begin
      errors++;
      $display("FAIL reset_mid first: got v%b (%b,%0d,%h) expected v1 (%b,%0d,%h)", out_valid,
               out_is_boolean, out_index, out_coefficient, e.kind, e.idx, e.coef);
    end
    @(posedge in_clk); #1;
    in_reset = 1'b1;
    @(posedge in_clk); #1;
    check_idle_outputs("reset_mid");
    check_count(0, "reset_mid");
    in_reset = 1'b0;
    in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge in_clk); #1;
      checks++;
      if (out_done !== 1'b0 || out_valid !== 1'b0 || out_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid quiet %0d: got done %b valid %b busy %b expected 0 0 0",
                 k, out_done, out_valid, out_busy);
      end
    end
    build_expected(8'h05, 4'b1111, n);
    do_start(8'h05, 4'b1111);
    run_stream(0, n, "reset_mid_restart");
  endtask

  task automatic test_busy_start();
    int n;
    build_expected(8'hA0, 4'b0100, n);
    in_ready = 1'b0;
    do_start(8'hA0, 4'b0100);
    in_integer_coefficients = 8'h55;
    in_boolean_coefficients = 4'b1010;
    in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    run_stream(0, n, "busy_start");
    check_count(n, "busy_start");
  endtask

  task automatic test_toggle();
    int n;
    build_expected(8'h55, 4'b1010, n);
    do_start(8'h55, 4'b1010);
    run_stream(2, 2 * n - 1, "toggle");
    check_count(n, "toggle");
  endtask

  // Start in the first idle cycle after the previous done pulse.
  task automatic test_back_to_back();
    int n;
    build_expected(8'h3C, 4'b0010, n);
    do_start(8'h3C, 4'b0010);
    run_stream(0, n, "back_to_back");
    check_count(n, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_reset_mid();
    test_busy_start();
    test_toggle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
